// File: rtl/test_rand_delay_source_if.sv
// Latency-insensitive val/rdy message channel between a test source and its consumer.
// The master drives val/msg and samples rdy; the slave does the opposite.
interface test_rand_delay_source_if #(
    parameter int p_msg_nbits = 1
);
    logic                   val;
    logic                   rdy;
    logic [p_msg_nbits-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/test_rand_delay_source.sv
// Test source: plays a bench-loaded message array out over val/rdy with LFSR-driven idle gaps.
// Optional build macro VC_TEST_SRC_TRACE_EN adds a per-cycle trace() task.
module test_rand_delay_source #(
    parameter int          p_msg_nbits = 1,
    parameter int          p_num_msgs  = 1024,
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_seed      = 16'hb9b9
) (
    input  logic                      clk,
    input  logic                      reset,
    test_rand_delay_source_if.master  src,
    output logic                      done
);
    localparam int c_idx_nbits  = $clog2(p_num_msgs) + 1;
    localparam int c_addr_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam int c_cnt_nbits  = $clog2(p_max_delay + 1) + 1;

    localparam logic [c_idx_nbits-1:0] c_end_index = c_idx_nbits'(p_num_msgs);
    localparam logic [15:0]            c_delay_mod = 16'(p_max_delay + 1);
    localparam logic [15:0]            c_lfsr_taps = 16'hB400;

    // NOTE: the message store has no reset; the bench loads it hierarchically and it must survive reset.
    logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];

    logic [c_idx_nbits-1:0] index;
    logic [c_cnt_nbits-1:0] cnt;
    logic [15:0]            lfsr;
    logic [15:0]            lfsr_next;
    logic [15:0]            delay_next;
    logic [p_msg_nbits-1:0] cur_msg;
    logic                   in_range;
    logic                   end_c;
    logic                   val_c;
    logic                   fire;

    // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
    always_comb begin
        in_range   = (index < c_end_index);
        cur_msg    = '0;
        if (in_range) cur_msg = m[index[c_addr_nbits-1:0]];
        // An unloaded (all-X) entry ends the stream early; only meaningful in 4-state simulation.
        end_c      = !in_range || (cur_msg === {p_msg_nbits{1'bx}});
        val_c      = !reset && !end_c && (cnt == '0);
        fire       = val_c && src.rdy;
        lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? c_lfsr_taps : 16'h0000);
        delay_next = lfsr_next % c_delay_mod;
    end

    assign src.val = val_c;
    assign src.msg = cur_msg;
    assign done    = !reset && end_c;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            index <= '0;
            cnt   <= '0;
            lfsr  <= p_seed;
        end else if (fire) begin
            index <= index + 1'b1;
            lfsr  <= lfsr_next;
            cnt   <= delay_next[c_cnt_nbits-1:0];
        end else if (!val_c && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef VC_TEST_SRC_TRACE_EN
    localparam int c_trace_nchars = (p_msg_nbits + 3) / 4;

    // Appends one fixed-width column per call: hex on transfer, '#' stall, '.' idle, blank when done.
    task automatic trace(inout string trace_str);
        string field;
        string pad;
        field = "";
        if (fire) begin
            field = $sformatf("%h", cur_msg);
        end else begin
            pad = val_c ? "#" : (done ? " " : ".");
            for (int i = 0; i < c_trace_nchars; i++) field = {field, pad};
        end
        trace_str = {trace_str, field};
    endtask
`endif

endmodule

// File: tb/tb_test_rand_delay_source.sv
// Scoreboard bench for test_rand_delay_source: four instances covering back-to-back,
// stall, random delay, mid-stream reset, random backpressure and end-of-array cases.
module tb_test_rand_delay_source;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done_a, done_b, done_c, done_d;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];

    logic [7:0]  msgs8  [6] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    logic [12:0] msgs13 [6] = '{13'h11aa, 13'h02bb, 13'h13cc, 13'h04dd, 13'h15ee, 13'h06ff};
    logic [7:0]  msgs4  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    test_rand_delay_source_if #(.p_msg_nbits(8))  if_a ();
    test_rand_delay_source_if #(.p_msg_nbits(8))  if_b ();
    test_rand_delay_source_if #(.p_msg_nbits(13)) if_c ();
    test_rand_delay_source_if #(.p_msg_nbits(8))  if_d ();

    test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(6), .p_max_delay(0), .p_seed(16'hb9b9))
        u_a (.clk(clk), .reset(reset), .src(if_a), .done(done_a));
    test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(6), .p_max_delay(4), .p_seed(16'hb9b9))
        u_b (.clk(clk), .reset(reset), .src(if_b), .done(done_b));
    test_rand_delay_source #(.p_msg_nbits(13), .p_num_msgs(6), .p_max_delay(3), .p_seed(16'hb9b9))
        u_c (.clk(clk), .reset(reset), .src(if_c), .done(done_c));
    test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(4), .p_max_delay(0), .p_seed(16'hb9b9))
        u_d (.clk(clk), .reset(reset), .src(if_d), .done(done_d));

    // Reference Galois LFSR step: shift right, fold in 0xB400 when a 1 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
    endfunction

    // Each cycle: step to just after the falling edge, then sample outputs and set rdy.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        if_a.rdy = 1'b0; if_b.rdy = 1'b0; if_c.rdy = 1'b0; if_d.rdy = 1'b0;
        repeat (n) next_cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({if_a.val, done_a, if_d.val, done_d} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: val_a,done_a,val_d,done_d = %b, want 0000", k,
                         {if_a.val, done_a, if_d.val, done_d});
            end
            next_cycle();
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({if_a.val, if_a.msg} !== {1'b1, 8'haa}) begin
            n_fail++;
            $display("FAIL reset_first_a: val=%b msg=%h, want val=1 msg=aa", if_a.val, if_a.msg);
        end
        n_tests++;
        if ({if_b.val, if_b.msg} !== {1'b1, 8'haa}) begin
            n_fail++;
            $display("FAIL reset_first_b_no_delay: val=%b msg=%h, want val=1 msg=aa", if_b.val, if_b.msg);
        end
        n_tests++;
        if ({if_c.val, if_c.msg} !== {1'b1, 13'h11aa}) begin
            n_fail++;
            $display("FAIL reset_first_c: val=%b msg=%h, want val=1 msg=11aa", if_c.val, if_c.msg);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        apply_reset(2);
        exp_q.delete();
        foreach (msgs8[i]) exp_q.push_back(16'(msgs8[i]));
        if_a.rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp = exp_q.pop_front();
            n_tests++;
            if ({if_a.val, done_a, 16'(if_a.msg)} !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL b2b_msg[%0d]: val=%b done=%b msg=%h, want val=1 done=0 msg=%h",
                         k, if_a.val, done_a, if_a.msg, exp);
            end
            next_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({if_a.val, done_a} !== 2'b01) begin
                n_fail++;
                $display("FAIL b2b_end[%0d]: val=%b done=%b, want val=0 done=1", k, if_a.val, done_a);
            end
            next_cycle();
        end
        if_a.rdy = 1'b0;
    endtask

    task automatic test_stall();
        apply_reset(1);
        exp_q.delete();
        exp_q.push_back(16'h00aa);
        exp_q.push_back(16'h00bb);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({if_a.val, 16'(if_a.msg)} !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: val=%b msg=%h, want val=1 msg=%h", k, if_a.val, if_a.msg, exp_q[0]);
            end
            next_cycle();
        end
        if_a.rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({if_a.val, 16'(if_a.msg)} !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL stall_release[%0d]: val=%b msg=%h, want val=1 msg=%h", k, if_a.val, if_a.msg, exp_q[0]);
            end
            void'(exp_q.pop_front());
            if (k == 0) next_cycle();
        end
        if_a.rdy = 1'b0;
    endtask

    task automatic test_random_delay();
        logic [15:0] lfsr_m = 16'hb9b9;
        int exp_gap = 0;
        int gap = 0;
        int cyc = 0;
        apply_reset(1);
        exp_q.delete();
        foreach (msgs8[i]) exp_q.push_back(16'(msgs8[i]));
        if_b.rdy = 1'b1;
        while (!done_b && cyc < 30) begin
            if (if_b.val) begin
                n_tests++;
                if (gap !== exp_gap || gap > 4) begin
                    n_fail++;
                    $display("FAIL rand_gap: idle cycles=%0d, want %0d (range 0..4)", gap, exp_gap);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: msg=%h, want no further message", if_b.msg);
                end else if (16'(if_b.msg) !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_msg: msg=%h, want %h", if_b.msg, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                lfsr_m  = lfsr_step(lfsr_m);
                exp_gap = int'(lfsr_m % 16'd5);
                gap     = 0;
            end else begin
                gap++;
            end
            next_cycle();
            cyc++;
        end
        n_tests++;
        if (!done_b || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_done: done=%b left=%0d after %0d cycles, want done=1 left=0 within 30",
                     done_b, exp_q.size(), cyc);
        end
        if_b.rdy = 1'b0;
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        apply_reset(1);
        if_a.rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({if_a.val, if_a.msg} !== {1'b1, msgs8[k]}) begin
                n_fail++;
                $display("FAIL midrst_pre[%0d]: val=%b msg=%h, want val=1 msg=%h", k, if_a.val, if_a.msg, msgs8[k]);
            end
            next_cycle();
        end
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({if_a.val, done_a} !== 2'b00) begin
                n_fail++;
                $display("FAIL midrst_during[%0d]: val=%b done=%b, want 0 0", k, if_a.val, done_a);
            end
            next_cycle();
        end
        reset = 1'b0;
        #1;
        exp_q.delete();
        foreach (msgs8[i]) exp_q.push_back(16'(msgs8[i]));
        while (!done_a && cyc < 12) begin
            if (if_a.val) begin
                n_tests++;
                if (exp_q.size() == 0 || 16'(if_a.msg) !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL midrst_replay: msg=%h, want %h (left=%0d)", if_a.msg,
                             (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx, exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            next_cycle();
            cyc++;
        end
        n_tests++;
        if (!done_a || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_done: done=%b left=%0d, want done=1 left=0", done_a, exp_q.size());
        end
        if_a.rdy = 1'b0;
    endtask

    task automatic test_random_rdy();
        logic        prev_stall = 1'b0;
        logic [12:0] prev_msg   = '0;
        int          cyc        = 0;
        apply_reset(1);
        exp_q.delete();
        foreach (msgs13[i]) exp_q.push_back(16'(msgs13[i]));
        while (!done_c && cyc < 300) begin
            if_c.rdy = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                n_tests++;
                if ({if_c.val, if_c.msg} !== {1'b1, prev_msg}) begin
                    n_fail++;
                    $display("FAIL rrdy_stable: val=%b msg=%h, want val=1 msg=%h", if_c.val, if_c.msg, prev_msg);
                end
            end
            if (if_c.val && if_c.rdy) begin
                n_tests++;
                if (exp_q.size() == 0 || 16'(if_c.msg) !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rrdy_msg: msg=%h, want %h (left=%0d)", if_c.msg,
                             (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx, exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_stall = if_c.val && !if_c.rdy;
            prev_msg   = if_c.msg;
            next_cycle();
            cyc++;
        end
        n_tests++;
        if (!done_c || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rrdy_done: done=%b left=%0d after %0d cycles, want done=1 left=0", done_c, exp_q.size(), cyc);
        end
        if_c.rdy = 1'b0;
    endtask

    task automatic test_end_of_array();
        int fires = 0;
        apply_reset(1);
        exp_q.delete();
        foreach (msgs4[i]) exp_q.push_back(16'(msgs4[i]));
        if_d.rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (if_d.val) begin
                fires++;
                n_tests++;
                if (exp_q.size() == 0 || 16'(if_d.msg) !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL eoa_msg[%0d]: msg=%h, want %h (left=%0d)", k, if_d.msg,
                             (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx, exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            next_cycle();
        end
        n_tests++;
        if (fires != 4) begin
            n_fail++;
            $display("FAIL eoa_fires: fires=%0d, want 4", fires);
        end
        n_tests++;
        if ({if_d.val, done_d, if_d.msg} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL eoa_idle: val=%b done=%b msg=%h, want val=0 done=1 msg=00", if_d.val, done_d, if_d.msg);
        end
        if_d.rdy = 1'b0;
    endtask

    initial begin
        if_a.rdy = 1'b0; if_b.rdy = 1'b0; if_c.rdy = 1'b0; if_d.rdy = 1'b0;
        foreach (msgs8[i]) begin
            u_a.m[i] = msgs8[i];
            u_b.m[i] = msgs8[i];
        end
        foreach (msgs13[i]) u_c.m[i] = msgs13[i];
        foreach (msgs4[i])  u_d.m[i] = msgs4[i];
        next_cycle();
        test_reset();
        test_back_to_back();
        test_stall();
        test_random_delay();
        test_mid_reset();
        test_random_rdy();
        test_end_of_array();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/test_rand_delay_source.md
Name: test_rand_delay_source

Overview:
- Test-bench message transmitter for the val/rdy latency-insensitive protocol. It drives the same interface that the test sink consumes.
- Plays out a bench-loaded message array in order. A pseudo-random number of idle cycles (0..p_max_delay) is inserted before each message, to stress sink backpressure and bubble handling.
- Sits in unit-test harnesses facing either a DUT input port or a test sink directly.

Parameters:
- p_msg_nbits, 1, message width in bits.
- p_num_msgs, 1024, depth of message array m[].
- p_max_delay, 0, maximum random idle cycles inserted before each message. 0 gives back-to-back operation.
- p_seed, 16'hb9b9, LFSR seed. Must be nonzero.

Ports:
- clk, input, 1, clock. All state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- val, output, 1, message valid.
- rdy, input, 1, consumer ready.
- msg, output, p_msg_nbits, message payload, m[index].
- done, output, 1, all messages transferred.

Behaviour:
- Storage: reg array m[0:p_num_msgs-1], p_msg_nbits wide. Written hierarchically by the bench before reset deasserts. Never written by the block and not cleared by reset.
- State:
  - index: width $clog2(p_num_msgs)+1.
  - delay counter cnt: width $clog2(p_max_delay+1)+1.
  - lfsr: 16b.
- End condition end_c = (index == p_num_msgs) || (m[index] === {p_msg_nbits{1'bx}}). An unloaded entry terminates the stream. This is a simulation-only check, acceptable for test code.
- done = !reset && end_c, combinational. Reset value 0.
- val = !reset && !end_c && (cnt == 0), combinational. Reset value 0.
- msg = m[index] whenever val=1. Don't-care when val=0, but must not be X-driven from out-of-range index; drive 0 when index == p_num_msgs.
- Transfer (fire) = val && rdy, sampled at posedge.
- On fire:
  - index <= index+1.
  - lfsr advances one step.
  - cnt <= next_lfsr % (p_max_delay+1).
  - With p_max_delay=0, cnt always 0, so val may stay high for consecutive fires.
- When val=0 and cnt>0, cnt decrements by 1 per cycle regardless of rdy.
- Protocol rules:
  - Once val=1, val and msg hold stable until fire. The counter does not decrement while val=1.
  - Reaching the end condition after the final fire drops val in the next cycle and raises done.
- LFSR: 16b Galois, taps mask 16'hB400. Shift right; if the shifted-out bit is 1, XOR in the mask. Reset value p_seed.
- Reset (any cycle, including mid-stream):
  - index <= 0, cnt <= 0, lfsr <= p_seed.
  - val=0 and done=0 while reset is high.
  - In the first cycle after reset deasserts, val=1 if m[0] is loaded. The first message has no initial delay.
- rdy high while val low has no effect. rdy is never required to be high.

Optional Feature:
- Macro: VC_TEST_SRC_TRACE_EN.
- Defined: the module provides task trace(inout trace_str). Each cycle it appends a fixed-width field of ceil(p_msg_nbits/4) characters:
  - hex msg on fire;
  - "#" padded when val && !rdy (stall);
  - "." padded when !val and not done;
  - spaces when done.
- Not defined: no trace task and no trace state; harnesses must not call it. Port behaviour is identical in both builds.

Test Plan:
1. p_max_delay=0; load 8'haa,bb,cc,dd,ee,ff; rdy=1 constantly -> val=1 for 6 consecutive cycles after reset, msgs aa..ff in order; done=1 on cycle 7; val=0 thereafter.
2. p_max_delay=0; rdy=0 for 3 cycles while val=1 at index 0 -> msg holds 8'haa, val stays 1, index stays 0; fire on first rdy=1 cycle, then 8'hbb next cycle.
3. p_max_delay=4, p_seed=16'hb9b9; rdy=1 -> gap before each message after the first equals the golden model's lfsr%5 sequence, each within 0..4; all 6 delivered in order; done within 30 cycles.
4. Assert reset for 2 cycles after the 3rd fire (8'hcc) -> val=0 and done=0 during reset; first fire after reset carries 8'haa; full sequence replays; done asserts.
5. 13-bit instance with 13'h11aa,02bb,13cc,04dd,15ee,06ff; p_max_delay=3; rdy from independent random pattern -> order preserved, no duplicates or drops, val/msg never change while stalled.
6. p_num_msgs=4, all 4 entries loaded, rdy=1 -> done after exactly 4 fires; index stops at 4; msg drives 0, not X.
